divider_with_interface: RTL and testbench

//  16/16 unsigned restoring divider behind an 8-bit byte-serial bus interface.
//  - Collects dividend and divisor as 4 bytes, computes quotient and remainder
//    one bit per clock, and returns 4 result bytes under a receiver handshake.
//  - Used as a standalone arithmetic peripheral on a byte-wide data bus.

---
 rtl/divider_pkg.sv | 12 +
 rtl/restoring_divider_core.sv | 64 ++++++
 rtl/divider_with_interface.sv | 111 +++++++++++
 tb/tb_divider_with_interface.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants and the interface FSM state type for the byte-serial divider.
package divider_pkg;
   localparam int DW = 16;
   localparam int BW = 8;
   localparam int NB = DW / BW;

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      OUTPUT
   } state_t;
endpackage

// File: rtl/restoring_divider_core.sv
// Unsigned restoring divider, one quotient bit per clock; load on start, done pulses after DW iterations.
// No backpressure: start is honoured whenever asserted and results hold until the next start.
module restoring_divider_core
   import divider_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [DW-1:0] remainder
);
   localparam int CW = $clog2(DW + 1);

   logic [DW-1:0] accReg;
   logic [DW-1:0] qReg;
   logic [DW-1:0] mReg;
   logic [CW-1:0] iterCnt;
   logic [DW:0]   accShift;
   logic [DW-1:0] diff;
   logic          fits;

   // The partial remainder is always below M, so the shifted value fits in DW+1
   // bits and a successful subtraction result fits back into DW bits.
   always_comb begin
      accShift = {accReg, qReg[DW-1]};
      fits     = (accShift >= {1'b0, mReg});
      diff     = accShift[DW-1:0] - mReg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         accReg  <= '0;
         qReg    <= '0;
         mReg    <= '0;
         iterCnt <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         accReg  <= '0;
         qReg    <= dividend;
         mReg    <= divisor;
         iterCnt <= CW'(DW);
         busy    <= 1'b1;
         done    <= 1'b0;
      end else if (busy) begin
         accReg  <= fits ? diff : accShift[DW-1:0];
         qReg    <= {qReg[DW-2:0], fits};
         iterCnt <= iterCnt - CW'(1);
         if (iterCnt == CW'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

   assign quotient  = qReg;
   assign remainder = accReg;
endmodule

// File: rtl/divider_with_interface.sv
// Byte-serial 16/16 divider peripheral: 4 operand bytes in, 4 result bytes out; OutBuffFull 17 clocks after last capture.
// Sender retries bytes offered outside LOAD; result bytes wait for ReceiveData rising edges.
module divider_with_interface
   import divider_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          StartData,
   input  logic [BW-1:0] DataIn,
   input  logic          ReceiveData,
   output logic          ReadyToAccept,
   output logic          Valid,
   output logic          OutBuffFull,
   output logic [BW-1:0] DataOut
);
   localparam int OPW = 2 * DW - BW;
   localparam int BCW = $clog2(2 * NB);
   localparam logic [BCW-1:0] LAST = BCW'(2 * NB - 1);

   state_t          state;
   logic            armed;
   logic            rxPrev;
   logic [BCW-1:0]  inCnt;
   logic [BCW-1:0]  outCnt;
   logic [OPW-1:0]  opReg;
   logic [2*DW-1:0] resBuf;
   logic [2*DW-1:0] opWord;
   logic            capture;
   logic            deliver;
   logic            coreStart;
   logic            coreBusy;
   logic            coreDone;
   logic [DW-1:0]   quotient;
   logic [DW-1:0]   remainder;

   assign capture   = (state == LOAD) && StartData && armed;
   assign deliver   = OutBuffFull && ReceiveData && !rxPrev;
   assign opWord    = {opReg, DataIn};
   // The core loads straight from the bus on the final capture edge, saving a cycle.
   assign coreStart = capture && (inCnt == LAST);

   restoring_divider_core uCore (
      .clk       (clk),
      .reset     (reset),
      .start     (coreStart),
      .dividend  (opWord[2*DW-1:DW]),
      .divisor   (opWord[DW-1:0]),
      .busy      (coreBusy),
      .done      (coreDone),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= LOAD;
         armed         <= 1'b1;
         rxPrev        <= 1'b0;
         inCnt         <= '0;
         outCnt        <= '0;
         opReg         <= '0;
         resBuf        <= '0;
         ReadyToAccept <= 1'b0;
         Valid         <= 1'b0;
         OutBuffFull   <= 1'b0;
         DataOut       <= '0;
      end else begin
         ReadyToAccept <= capture;
         Valid         <= deliver;
         rxPrev        <= ReceiveData;
         if (capture) begin
            armed <= 1'b0;
         end else if (!StartData) begin
            armed <= 1'b1;
         end

         case (state)
            LOAD: begin
               if (capture) begin
                  opReg <= opWord[OPW-1:0];
                  inCnt <= inCnt + BCW'(1);
                  if (inCnt == LAST) begin
                     inCnt <= '0;
                     state <= COMPUTE;
                  end
               end
            end
            COMPUTE: begin
               if (coreDone && !coreBusy) begin
                  resBuf      <= {quotient, remainder};
                  OutBuffFull <= 1'b1;
                  outCnt      <= '0;
                  state       <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (deliver) begin
                  DataOut <= resBuf[2*DW-1 -: BW];
                  resBuf  <= {resBuf[2*DW-BW-1:0], {BW{1'b0}}};
                  outCnt  <= outCnt + BCW'(1);
                  if (outCnt == LAST) begin
                     OutBuffFull <= 1'b0;
                     state       <= LOAD;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_divider_with_interface.sv
// Bench for the byte-serial divider: vector table, corner-case sequences and random operands vs an arithmetic model.
module tb_divider_with_interface;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       StartData = 1'b0;
   logic       ReceiveData = 1'b0;
   logic [7:0] DataIn = 8'h00;
   logic       ReadyToAccept;
   logic       Valid;
   logic       OutBuffFull;
   logic [7:0] DataOut;

   int passCnt = 0;
   int checkCnt = 0;
   int cyc = 0;
   int rtaCnt = 0;
   int validCnt = 0;
   int lastCap = 0;

   typedef struct {
      logic [15:0] dividend;
      logic [15:0] divisor;
      logic [15:0] quot;
      logic [15:0] rem;
   } vec_t;
   vec_t vecs[6];

   divider_with_interface dut (
      .clk           (clk),
      .reset         (reset),
      .StartData     (StartData),
      .DataIn        (DataIn),
      .ReceiveData   (ReceiveData),
      .ReadyToAccept (ReadyToAccept),
      .Valid         (Valid),
      .OutBuffFull   (OutBuffFull),
      .DataOut       (DataOut)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      #1;
      if (ReadyToAccept === 1'b1) rtaCnt++;
      if (Valid === 1'b1) validCnt++;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 1000000");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic logic [31:0] refDiv(input logic [15:0] a, input logic [15:0] b);
      if (b == 16'd0) return {16'hFFFF, a};
      return {a / b, a % b};
   endfunction

   task automatic sendByte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      StartData = 1'b1;
      DataIn = b;
      while (ReadyToAccept !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("capture", {31'd0, ReadyToAccept}, 32'd1);
      StartData = 1'b0;
      lastCap = cyc;
   endtask

   task automatic sendOperands(input logic [15:0] a, input logic [15:0] b);
      sendByte(a[15:8]);
      sendByte(a[7:0]);
      sendByte(b[15:8]);
      sendByte(b[7:0]);
   endtask

   task automatic finishTxn(input logic [31:0] exp, input bit heldRx, input bit probeOut);
      int n = 0;
      int v0;
      int r0;
      logic [7:0] d;
      logic [7:0] eb;
      while (OutBuffFull !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("full_latency", cyc - lastCap, 32'd17);
      if (probeOut) begin
         r0 = rtaCnt;
         StartData = 1'b1;
         DataIn = 8'hA5;
         repeat (4) @(negedge clk);
         StartData = 1'b0;
         check("rta_in_output", rtaCnt - r0, 32'd0);
         @(negedge clk);
      end
      v0 = validCnt;
      for (int i = 0; i < 4; i++) begin
         eb = exp[31 - 8*i -: 8];
         @(negedge clk);
         ReceiveData = 1'b1;
         if (heldRx && i == 0) begin
            r0 = validCnt;
            repeat (3) @(negedge clk);
            check("held_rx_one_byte", validCnt - r0, 32'd1);
         end else begin
            @(negedge clk);
            check("valid_pulse", {31'd0, Valid}, 32'd1);
         end
         d = DataOut;
         ReceiveData = 1'b0;
         check($sformatf("byte%0d", i), {24'd0, d}, {24'd0, eb});
      end
      @(negedge clk);
      @(negedge clk);
      check("full_cleared", {31'd0, OutBuffFull}, 32'd0);
      check("valid_count", validCnt - v0, 32'd4);
      check("dataout_hold", {24'd0, DataOut}, {24'd0, exp[7:0]});
   endtask

   task automatic checkOutputsZero(input string tag);
      check({tag, "_rta"},   {31'd0, ReadyToAccept}, 32'd0);
      check({tag, "_valid"}, {31'd0, Valid}, 32'd0);
      check({tag, "_full"},  {31'd0, OutBuffFull}, 32'd0);
      check({tag, "_dout"},  {24'd0, DataOut}, 32'd0);
   endtask

   initial begin
      int r0;
      logic [15:0] a;
      logic [15:0] b;
      vecs[0] = '{16'h569D, 16'h0585, 16'h000F, 16'h03D2};
      vecs[1] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234};
      vecs[2] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002};
      vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
      vecs[4] = '{16'h0005, 16'h0009, 16'h0000, 16'h0005};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};

      repeat (3) @(negedge clk);
      checkOutputsZero("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         sendOperands(vecs[i].dividend, vecs[i].divisor);
         finishTxn({vecs[i].quot, vecs[i].rem}, 1'b0, 1'b0);
      end

      // StartData held for 5 cycles must capture exactly the first byte.
      r0 = rtaCnt;
      @(negedge clk);
      StartData = 1'b1;
      DataIn = 8'h00;
      repeat (5) @(negedge clk);
      StartData = 1'b0;
      check("held_start_one_capture", rtaCnt - r0, 32'd1);
      sendByte(8'h64);
      sendByte(8'h00);
      sendByte(8'h07);
      finishTxn(32'h000E_0002, 1'b0, 1'b0);

      // StartData offered during COMPUTE and OUTPUT; ReceiveData held on the first byte.
      sendOperands(16'h1234, 16'h0056);
      r0 = rtaCnt;
      @(negedge clk);
      StartData = 1'b1;
      DataIn = 8'h5A;
      repeat (8) @(negedge clk);
      StartData = 1'b0;
      check("rta_in_compute", rtaCnt - r0, 32'd0);
      finishTxn(refDiv(16'h1234, 16'h0056), 1'b1, 1'b1);

      // Reset mid-compute, then mid-load, then a clean transaction.
      sendOperands(16'hBEEF, 16'h0013);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutputsZero("abort");
      reset = 1'b1;
      sendByte(8'h77);
      sendByte(8'h88);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      sendOperands(16'h0064, 16'h0007);
      finishTxn(32'h000E_0002, 1'b0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
         else b = 16'($urandom);
         sendOperands(a, b);
         finishTxn(refDiv(a, b), 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
